// File: rtl/ct_idu_is_aiq_lch_sched.sv
// Launch scheduler for the AIQ: tracks per-entry IDLE/WAIT/ISSUED state and
// offers the oldest launch-ready entry to the issue pipe using an age matrix.
module ct_idu_is_aiq_lch_sched #(
  parameter int ENTRY = 8
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             x_create_en,
  input  logic [ENTRY-1:0] x_create_entry,
  input  logic             x_create_lch_rdy,
  input  logic [ENTRY-1:0] x_entry_lch_rdy,
  input  logic             x_pipe_stall,
  input  logic             x_pipe_rdy,
  input  logic [ENTRY-1:0] x_lch_fail,
  input  logic [ENTRY-1:0] x_pop,
  input  logic             x_flush,
  output logic             x_issue_vld,
  output logic [ENTRY-1:0] x_issue_entry,
  output logic [ENTRY-1:0] x_entry_vld,
  output logic             x_full,
  output logic             x_empty,
  output logic             x_proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUED = 2'd2
  } ent_state_e;

  ent_state_e [ENTRY-1:0]            state_q, state_d;
  logic       [ENTRY-1:0]            rdy_q, rdy_d;
  // age_q[i][j] set means entry i is older than entry j
  logic       [ENTRY-1:0][ENTRY-1:0] age_q, age_d;
  logic                              proto_err_q, proto_err_d;

  logic [ENTRY-1:0] valid, waiting, issued;
  logic [ENTRY-1:0] eligible, older_elig, grant;
  logic [ENTRY-1:0] create_hit, pop_ok, fail_ok;
  logic             create_bad, create_ok, evict_bad, violation, fire;

  // ---------------------------------------------------------------------------
  // Selection: an entry is granted when it is eligible and no older entry is.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    valid      = '0;
    waiting    = '0;
    issued     = '0;
    older_elig = '0;
    for (int i = 0; i < ENTRY; i++) begin
      valid[i]   = (state_q[i] != ST_IDLE);
      waiting[i] = (state_q[i] == ST_WAIT);
      issued[i]  = (state_q[i] == ST_ISSUED);
    end
    eligible = waiting & (x_entry_lch_rdy | rdy_q);
    for (int i = 0; i < ENTRY; i++) begin
      for (int j = 0; j < ENTRY; j++) begin
        if (eligible[j] && age_q[j][i]) older_elig[i] = 1'b1;
      end
    end
    grant         = eligible & ~older_elig;
    x_issue_vld   = (|eligible) && !x_pipe_stall && !x_flush;
    x_issue_entry = x_issue_vld ? grant : '0;
    fire          = x_issue_vld && x_pipe_rdy;
  end

  // ---------------------------------------------------------------------------
  // Protocol screening: illegal requests are dropped and flagged.
  // ---------------------------------------------------------------------------
  always_comb begin
    create_bad = x_create_en && (!$onehot(x_create_entry) || |(x_create_entry & valid));
    create_ok  = x_create_en && !create_bad;
    create_hit = create_ok ? x_create_entry : '0;
    evict_bad  = |(x_pop & ~issued) || |(x_lch_fail & ~issued) || |(x_pop & x_lch_fail);
    pop_ok     = x_pop & issued & ~x_lch_fail;
    fail_ok    = x_lch_fail & issued & ~x_pop;
    violation  = !x_flush && (create_bad || evict_bad);
  end

  // ---------------------------------------------------------------------------
  // Next-state: events on one entry are mutually exclusive by construction
  // (create needs IDLE, fire needs WAIT, pop/fail need ISSUED).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rdy_d       = rdy_q;
    age_d       = age_q;
    proto_err_d = proto_err_q || violation;
    if (x_flush) begin
      for (int i = 0; i < ENTRY; i++) state_d[i] = ST_IDLE;
      rdy_d = '0;
    end else begin
      for (int i = 0; i < ENTRY; i++) begin
        if (create_hit[i]) begin
          state_d[i] = ST_WAIT;
          rdy_d[i]   = x_create_lch_rdy;
          age_d[i]   = '0;
        end else if (fire && grant[i]) begin
          state_d[i] = ST_ISSUED;
          rdy_d[i]   = 1'b0;
        end else if (fail_ok[i]) begin
          state_d[i] = ST_WAIT;
          rdy_d[i]   = 1'b0;
        end else if (pop_ok[i]) begin
          state_d[i] = ST_IDLE;
        end
        // Survivors become older than the entry being created.
        if (create_ok && valid[i] && !pop_ok[i]) age_d[i] = age_q[i] | x_create_entry;
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (cpurst) begin
      for (int i = 0; i < ENTRY; i++) state_q[i] <= ST_IDLE;
      rdy_q       <= '0;
      // NOTE: the age matrix is a small flop array, not a RAM, so it is cleared
      // on reset to give a deterministic ordering state.
      age_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      age_q       <= age_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign x_entry_vld = valid;
  assign x_full      = &valid;
  assign x_empty     = ~|valid;
  assign x_proto_err = proto_err_q;

endmodule

// File: tb/tb_ct_idu_is_aiq_lch_sched.sv
// Self-checking bench for the AIQ launch scheduler: directed scenarios then
// random traffic, all compared against a queue-based age-order model.
module tb_ct_idu_is_aiq_lch_sched;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         cpurst, create_en, create_lch_rdy, pipe_stall, pipe_rdy, flush;
  logic [N-1:0] create_entry, entry_lch_rdy, lch_fail, pop;
  logic         issue_vld, full, empty, proto_err;
  logic [N-1:0] issue_entry, entry_vld;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 wait, 2 issued; age order is a queue, oldest first.
  int mstate [N];
  bit mrdy   [N];
  int morder [$];
  bit merr;

  ct_idu_is_aiq_lch_sched #(.ENTRY(N)) dut (
    .forever_cpuclk   (clk),
    .cpurst           (cpurst),
    .x_create_en      (create_en),
    .x_create_entry   (create_entry),
    .x_create_lch_rdy (create_lch_rdy),
    .x_entry_lch_rdy  (entry_lch_rdy),
    .x_pipe_stall     (pipe_stall),
    .x_pipe_rdy       (pipe_rdy),
    .x_lch_fail       (lch_fail),
    .x_pop            (pop),
    .x_flush          (flush),
    .x_issue_vld      (issue_vld),
    .x_issue_entry    (issue_entry),
    .x_entry_vld      (entry_vld),
    .x_full           (full),
    .x_empty          (empty),
    .x_proto_err      (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    cpurst = 1'b0; create_en = 1'b0; create_entry = '0; create_lch_rdy = 1'b0;
    entry_lch_rdy = '0; pipe_stall = 1'b0; pipe_rdy = 1'b0;
    lch_fail = '0; pop = '0; flush = 1'b0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin mstate[i] = 0; mrdy[i] = 1'b0; end
    morder.delete();
    merr = 1'b0;
  endtask

  function automatic int m_oldest();
    for (int n = 0; n < morder.size(); n++) begin
      int e = morder[n];
      if (mstate[e] == 1 && (entry_lch_rdy[e] || mrdy[e])) return e;
    end
    return -1;
  endfunction

  task automatic m_update(input int g, input bit vld);
    int ns [N];
    bit nr [N];
    bit ce_ok = 1'b0;
    int k = 0;
    if (cpurst) begin m_reset(); return; end
    if (flush) begin
      for (int i = 0; i < N; i++) begin mstate[i] = 0; mrdy[i] = 1'b0; end
      morder.delete();
      return;
    end
    ns = mstate;
    nr = mrdy;
    if (create_en) begin
      for (int i = 0; i < N; i++) if (create_entry[i]) k = i;
      if ($countones(create_entry) != 1 || mstate[k] != 0) merr = 1'b1;
      else ce_ok = 1'b1;
    end
    if (vld && pipe_rdy) begin ns[g] = 2; nr[g] = 1'b0; end
    for (int i = 0; i < N; i++) begin
      if (pop[i] && lch_fail[i]) merr = 1'b1;
      else if (pop[i]) begin
        if (mstate[i] == 2) begin
          ns[i] = 0;
          for (int n = 0; n < morder.size(); n++)
            if (morder[n] == i) begin morder.delete(n); break; end
        end else merr = 1'b1;
      end else if (lch_fail[i]) begin
        if (mstate[i] == 2) begin ns[i] = 1; nr[i] = 1'b0; end
        else merr = 1'b1;
      end
    end
    if (ce_ok) begin ns[k] = 1; nr[k] = create_lch_rdy; morder.push_back(k); end
    mstate = ns;
    mrdy   = nr;
  endtask

  // One cycle: inputs already applied; check mid-cycle, then advance model at the edge.
  task automatic step(input string tag, input int want);
    int           g;
    logic         exp_vld;
    logic [N-1:0] exp_entry, exp_valid;
    #4;
    g         = m_oldest();
    exp_vld   = (g >= 0) && !pipe_stall && !flush;
    exp_entry = exp_vld ? (N'(1) << g) : '0;
    for (int i = 0; i < N; i++) exp_valid[i] = (mstate[i] != 0);
    check({tag, "_issue_vld"},   32'(issue_vld),   32'(exp_vld));
    check({tag, "_issue_entry"}, 32'(issue_entry), 32'(exp_entry));
    check({tag, "_entry_vld"},   32'(entry_vld),   32'(exp_valid));
    check({tag, "_full"},        32'(full),        32'(&exp_valid));
    check({tag, "_empty"},       32'(empty),       32'(~|exp_valid));
    check({tag, "_proto_err"},   32'(proto_err),   32'(merr));
    if (want >= 0) check({tag, "_directed"}, 32'(issue_entry), 32'(want));
    @(posedge clk);
    m_update(g, exp_vld);
    #1;
    clr_in();
  endtask

  task automatic create(input int e, input bit r);
    create_en = 1'b1; create_entry = N'(1) << e; create_lch_rdy = r;
  endtask

  function automatic logic [N-1:0] pick(input int st);
    int cand [$];
    for (int i = 0; i < N; i++) if (mstate[i] == st) cand.push_back(i);
    if (cand.size() == 0) return '0;
    return N'(1) << cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  initial begin
    clr_in();
    cpurst = 1'b1;
    repeat (2) @(posedge clk);
    m_reset();
    #1;
    clr_in();
    step("reset", 0);

    // Two ready entries issue in creation order on consecutive cycles.
    create(2, 1); pipe_rdy = 1'b1; step("r37_c2", 0);
    create(5, 1); pipe_rdy = 1'b1; step("r37_c5", 8'h04);
    pipe_rdy = 1'b1;               step("r37_i5", 8'h20);
    pop = 8'h04;                   step("r37_p2", 0);
    pop = 8'h20;                   step("r37_p5", 0);

    // Younger entry issues first when it alone is ready.
    create(0, 0);                          step("r38a_c0", 0);
    create(1, 1);                          step("r38a_c1", 0);
    pipe_rdy = 1'b1;                       step("r38a_i1", 8'h02);
    entry_lch_rdy = 8'h01; pipe_rdy = 1'b1; step("r38a_i0", 8'h01);
    pop = 8'h01;                           step("r38a_p0", 0);
    pop = 8'h02;                           step("r38a_p1", 0);
    // Both ready together: the older one wins.
    create(0, 0);                          step("r38b_c0", 0);
    create(1, 0);                          step("r38b_c1", 0);
    entry_lch_rdy = 8'h03;                 step("r38b_offer", 8'h01);
    entry_lch_rdy = 8'h03; pipe_rdy = 1'b1; step("r38b_i0", 8'h01);
    entry_lch_rdy = 8'h02; pipe_rdy = 1'b1; step("r38b_i1", 8'h02);
    pop = 8'h01;                           step("r38b_p0", 0);
    pop = 8'h02;                           step("r38b_p1", 0);

    // Failed launch returns to WAIT, keeps its age, needs a fresh ready.
    create(3, 1);                          step("r39_c3", 0);
    pipe_rdy = 1'b1;                       step("r39_i3", 8'h08);
    lch_fail = 8'h08; create(4, 0);        step("r39_f3", 0);
    pipe_rdy = 1'b1;                       step("r39_norr", 0);
    entry_lch_rdy = 8'h18;                 step("r39_old", 8'h08);
    entry_lch_rdy = 8'h18; pipe_rdy = 1'b1; step("r39_re3", 8'h08);
    entry_lch_rdy = 8'h10; pipe_rdy = 1'b1; step("r39_i4", 8'h10);
    pop = 8'h08;                           step("r39_p3", 0);
    pop = 8'h10;                           step("r39_p4", 0);

    // Fill all entries, then free one.
    for (int i = 0; i < N; i++) begin create(i, 0); step("r40_fill", 0); end
    entry_lch_rdy = 8'h01; pipe_rdy = 1'b1; step("r40_i0", 8'h01);
    pop = 8'h01;                           step("r40_p0", 0);
    check("r40_full_drop", 32'(full), 32'(0));
    flush = 1'b1;                          step("r40_flush", 0);

    // Flush with an offered issue suppresses it in the same cycle.
    for (int i = 0; i < 4; i++) begin create(i, 1); pipe_stall = 1'b1; step("r41_fill", -1); end
    flush = 1'b1; pipe_rdy = 1'b1; create(7, 1); step("r41_flush", 0);
    step("r41_after", 0);
    check("r41_empty", 32'(empty), 32'(1));

    // Protocol violations are ignored and flagged until reset.
    create(6, 0);                          step("r42_c6", 0);
    create(6, 1);                          step("r42_dup", 0);
    pipe_rdy = 1'b1;                       step("r42_rdykept", 0);
    pop = 8'h40;                           step("r42_popwait", 0);
    create_en = 1'b1; create_entry = 8'h03; step("r42_multi", 0);
    entry_lch_rdy = 8'h40; pipe_rdy = 1'b1; step("r42_i6", 8'h40);
    pop = 8'h40; lch_fail = 8'h40;         step("r42_both", 0);
    pop = 8'h40; create(6, 1);             step("r42_popcreate", 0);
    create(6, 1);                          step("r42_recreate", 0);
    check("r42_sticky", 32'(proto_err), 32'(1));
    cpurst = 1'b1; flush = 1'b1;           step("r42_reset", -1);
    step("r42_cleared", 0);

    // Random legal traffic.
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        create_entry = pick(0);
        create_en = (create_entry != '0);
        create_lch_rdy = 1'($urandom);
      end
      if ($urandom_range(0, 9) < 3) pop = pick(2);
      if ($urandom_range(0, 9) < 2) begin
        lch_fail = pick(2);
        if (lch_fail == pop) lch_fail = '0;
      end
      entry_lch_rdy = N'($urandom) & N'($urandom);
      pipe_stall = ($urandom_range(0, 9) < 2);
      pipe_rdy   = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 49) == 0);
      step("rand", -1);
    end

    // Reset wins over a flush and a completing handshake in the same cycle.
    for (int i = 0; i < 3; i++) begin create(i, 1); step("r36_fill", -1); end
    cpurst = 1'b1; flush = 1'b1; pipe_rdy = 1'b1; create(7, 1); step("r36_reset", -1);
    step("r36_after", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ct_idu_is_aiq_lch_sched.md
CT_IDU_IS_AIQ_LCH_SCHED -- requirements
Module: ct_idu_is_aiq_lch_sched

Interface
REQ-001 SHALL have parameter ENTRY, default 8: number of AIQ entries scheduled.
REQ-002 SHALL have port forever_cpuclk  in  1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port cpurst  in  1: synchronous, active-high reset.
REQ-004 SHALL have port x_create_en  in  1: create one entry this cycle.
REQ-005 SHALL have port x_create_entry  in  ENTRY: one-hot index of the entry to create.
REQ-006 SHALL have port x_create_lch_rdy  in  1: launch-ready value captured for the created entry.
REQ-007 SHALL have port x_entry_lch_rdy  in  ENTRY: per-entry live launch-ready bits from entry logic.
REQ-008 SHALL have port x_pipe_stall  in  1: issue pipe cannot accept; blocks issue.
REQ-009 SHALL have port x_pipe_rdy  in  1: pipe accepts the offered issue this cycle.
REQ-010 SHALL have port x_lch_fail  in  ENTRY: one-hot; issued entry failed launch, return to wait.
REQ-011 SHALL have port x_pop  in  ENTRY: one-hot; issued entry retired, free it.
REQ-012 SHALL have port x_flush  in  1: kill all entries.
REQ-013 SHALL have port x_issue_vld  out  1: an issue is offered.
REQ-014 SHALL have port x_issue_entry  out  ENTRY: one-hot grant; all-zero when x_issue_vld=0.
REQ-015 SHALL have port x_entry_vld  out  ENTRY: entry in WAIT or ISSUED.
REQ-016 SHALL have port x_full / x_empty  out  1 each: all ENTRY entries valid / none valid.
REQ-017 SHALL have port x_proto_err  out  1: sticky protocol-violation flag.

Function
REQ-018 SHALL keep a per-entry state: IDLE, WAIT, ISSUED, plus per-entry registered rdy bit.
REQ-019 SHALL move IDLE->WAIT when x_create_en and x_create_entry selects the entry; rdy <= x_create_lch_rdy.
REQ-020 SHALL compute eligible[i] = (state WAIT) and (x_entry_lch_rdy[i] or rdy[i]).
REQ-021 SHALL drive x_issue_vld = |eligible and !x_pipe_stall, combinationally in the same cycle.
REQ-022 SHALL drive x_issue_entry as the oldest eligible entry, one-hot, by age matrix.
REQ-023 SHALL define fire = x_issue_vld and x_pipe_rdy; on fire granted entry WAIT->ISSUED, rdy cleared.
REQ-024 SHALL move ISSUED->WAIT on its x_lch_fail bit, rdy cleared; age unchanged.
REQ-025 SHALL move ISSUED->IDLE on its x_pop bit.
REQ-026 SHALL maintain age matrix age[i][j]=1 meaning i older than j; on create of k: age[j][k]<=1 for every valid j not popped this cycle, age[k][*]<=0.
REQ-027 SHALL keep the age order of surviving entries unchanged by pop, fail, or fire.
REQ-028 SHALL make a newly created entry ineligible in its create cycle; earliest issue is the next cycle.
REQ-029 SHALL let x_issue_entry change between cycles while x_pipe_rdy=0; no grant hold requirement.
REQ-030 SHALL give x_flush top priority: all entries -> IDLE, rdy cleared, same-cycle create/fire/pop ignored, x_issue_vld forced 0.
REQ-031 SHALL ignore and set x_proto_err on: create to non-IDLE entry, create with non-one-hot x_create_entry, x_pop or x_lch_fail on a non-ISSUED entry, x_pop and x_lch_fail on same entry same cycle.
REQ-032 SHALL allow create to an entry popped in the same cycle only from the next cycle; same-cycle create to it is a violation per REQ-031.
REQ-033 SHALL derive x_entry_vld, x_full, x_empty from registered state (post-edge).

Reset
REQ-034 SHALL on cpurst=1 at a clock edge set all entries IDLE, rdy=0, age=0, x_proto_err=0.
REQ-035 SHALL after reset present x_issue_vld=0, x_issue_entry=0, x_entry_vld=0, x_full=0, x_empty=1.
REQ-036 SHALL let reset override all other inputs including x_flush and mid-handshake fire.

Verification
REQ-037 SHALL cover: create e2 (rdy=1) then e5 (rdy=1), x_pipe_rdy=1 -> issue e2 then e5 on consecutive cycles.
REQ-038 SHALL cover: create e0 rdy=0, e1 rdy=1, then x_entry_lch_rdy[0]=1 -> e1 issued first if ready first; if both ready same cycle, e0 granted.
REQ-039 SHALL cover: issue e3, x_lch_fail[3] -> e3 WAIT, reissued only after rdy source re-asserts; older than later-created e4.
REQ-040 SHALL cover: fill 8 entries -> x_full=1; pop one issued -> x_full=0 next cycle.
REQ-041 SHALL cover: x_flush with 4 valid entries and offered issue -> x_issue_vld=0 same cycle, x_empty=1 next cycle.
REQ-042 SHALL cover: create to WAIT entry, and x_pop on WAIT entry -> state unchanged, x_proto_err=1 until reset.
